k10_uart: RTL and testbench

K10_UART -- requirements
Module: k10_uart

---
 rtl/k10_uart.sv | 220 ++++++++++++++++++++++
 tb/tb_k10_uart.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/k10_uart.sv
// k10_uart: AXI4-Lite slave driving a TX FIFO and an 8N1 serializer.
// Define K10_UART_IRQ_EN to build the registered TX-done interrupt and IRQ_EN register.
`timescale 1ns/1ps
module k10_uart #(
   parameter int unsigned FIFO_DEPTH = 8,
   parameter logic [15:0] DIV_RESET  = 16'd868
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [31:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic        o_tx,
   output logic        o_irq
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

   state_e      state_q, state_d;
   logic [AW:0] wptr_q, rptr_q, count;
   logic [7:0]  mem_q [FIFO_DEPTH];
   logic [15:0] div_q, div_lat_q, cnt_q, div_eff;
   logic [7:0]  shreg_q;
   logic [2:0]  bit_q;
   logic        tx_q, tx_d;
   logic        awready_q, bvalid_q, arready_q, rvalid_q;
   logic [1:0]  bresp_q;
   logic [31:0] rdata_q, rd_mux;
   logic        full, empty, busy, pop, push, push_req;
   logic        wr_hs, wr_en, rd_hs, bit_end;
   logic        unused;

   assign unused = ^{s_axi_awaddr[31:4], s_axi_awaddr[1:0], s_axi_araddr[31:4],
                     s_axi_araddr[1:0], s_axi_awprot, s_axi_arprot,
                     s_axi_wdata[31:16], s_axi_wstrb[3:1]};

   assign count    = wptr_q - rptr_q;
   assign empty    = (wptr_q == rptr_q);
   assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign busy     = (state_q != S_IDLE);
   assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
   assign bit_end  = (cnt_q == div_lat_q - 16'd1);

   assign wr_hs    = awready_q & s_axi_awvalid & s_axi_wvalid;
   assign wr_en    = wr_hs & s_axi_wstrb[0];
   assign rd_hs    = arready_q & s_axi_arvalid;
   assign push_req = wr_en && (s_axi_awaddr[3:2] == 2'd0);
   // A full FIFO still takes the byte when the serializer frees a slot this cycle.
   assign push     = push_req && (!full || pop);

   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      tx_d    = 1'b1;
      case (state_q)
         S_IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               state_d = S_START;
            end
         end
         S_START: begin
            tx_d = 1'b0;
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            tx_d = shreg_q[0];
            if (bit_end && (bit_q == 3'd7)) state_d = S_STOP;
         end
         S_STOP: begin
            if (bit_end) begin
               if (!empty) begin
                  pop     = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         if (push) wptr_q <= wptr_q + 1'b1;
         if (pop)  rptr_q <= rptr_q + 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (push) mem_q[wptr_q[AW-1:0]] <= s_axi_wdata[7:0];
   end

   // o_tx is registered from the current state, which yields the two-cycle write-to-start latency.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= S_IDLE;
         tx_q      <= 1'b1;
         shreg_q   <= '0;
         div_lat_q <= 16'd1;
         cnt_q     <= '0;
         bit_q     <= '0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         if (pop) begin
            shreg_q   <= mem_q[rptr_q[AW-1:0]];
            div_lat_q <= div_eff;
            cnt_q     <= '0;
            bit_q     <= '0;
         end else if (busy) begin
            if (bit_end) begin
               cnt_q <= '0;
               if (state_q == S_DATA) begin
                  shreg_q <= shreg_q >> 1;
                  bit_q   <= bit_q + 3'd1;
               end
            end else begin
               cnt_q <= cnt_q + 16'd1;
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q     <= DIV_RESET;
         awready_q <= 1'b0;
         bvalid_q  <= 1'b0;
         bresp_q   <= 2'b00;
      end else begin
         awready_q <= s_axi_awvalid & s_axi_wvalid & ~bvalid_q & ~awready_q;
         if (wr_en && (s_axi_awaddr[3:2] == 2'd2)) div_q <= s_axi_wdata[15:0];
         if (wr_hs) begin
            bvalid_q <= 1'b1;
            bresp_q  <= (push_req && !push) ? 2'b10 : 2'b00;
         end else if (s_axi_bready) begin
            bvalid_q <= 1'b0;
         end
      end
   end

`ifdef K10_UART_IRQ_EN
   logic irq_en_q, irq_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         irq_en_q <= 1'b0;
         irq_q    <= 1'b0;
      end else begin
         if (wr_en && (s_axi_awaddr[3:2] == 2'd3)) irq_en_q <= s_axi_wdata[0];
         irq_q <= irq_en_q & empty & ~busy;
      end
   end

   assign o_irq = irq_q;
`else
   assign o_irq = 1'b0;
`endif

   always_comb begin
      rd_mux = '0;
      case (s_axi_araddr[3:2])
         2'd1: rd_mux = {17'd0, 7'(count), 5'd0, busy, empty, full};
         2'd2: rd_mux = {16'd0, div_q};
`ifdef K10_UART_IRQ_EN
         2'd3: rd_mux = {31'd0, irq_en_q};
`endif
         default: rd_mux = '0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         arready_q <= 1'b0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
      end else begin
         arready_q <= s_axi_arvalid & ~rvalid_q & ~arready_q;
         if (rd_hs) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_mux;
         end else if (s_axi_rready) begin
            rvalid_q <= 1'b0;
         end
      end
   end

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = awready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = bresp_q;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;
   assign o_tx          = tx_q;

endmodule

// File: tb/tb_k10_uart.sv
// Scoreboard bench for k10_uart: B/R responses and serial frames are checked by monitors
// against expectations queued by the directed stimulus.
`timescale 1ns/1ps
module tb_k10_uart;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
`ifdef K10_UART_IRQ_EN
   localparam logic IRQ_ON = 1'b1;
`else
   localparam logic IRQ_ON = 1'b0;
`endif

   typedef struct {
      logic [7:0]  data;
      int unsigned div;
      bit          b2b;
   } frame_t;

   logic        clk, rst_n;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;
   logic        o_tx, o_irq;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc   = 0;
   logic [1:0]  b_exp[$];
   logic [31:0] r_exp[$];
   frame_t      tx_exp[$];
   bit          tx_mon_en = 1'b1;
   bit          mon_busy  = 1'b0;

   k10_uart #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
      .i_clk(clk), .i_rst_n(rst_n),
      .s_axi_awaddr(awaddr), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid),
      .s_axi_awready(awready), .s_axi_wdata(wdata), .s_axi_wstrb(wstrb),
      .s_axi_wvalid(wvalid), .s_axi_wready(wready), .s_axi_bresp(bresp),
      .s_axi_bvalid(bvalid), .s_axi_bready(bready), .s_axi_araddr(araddr),
      .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
      .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid),
      .s_axi_rready(rready), .o_tx(o_tx), .o_irq(o_irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #900us;
      $display("FAIL watchdog: simulation still running at 900us, required finish");
      $fatal(1);
   end

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endfunction

   // Write-response monitor.
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bvalid === 1'b1 && bready === 1'b1) begin
         if (b_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL b_unexpected: bvalid with bresp 0x%0h, required no response", bresp);
         end else begin
            chk("bresp", 32'(bresp), 32'(b_exp.pop_front()));
         end
      end
   end

   // Read-data monitor.
   initial forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && rvalid === 1'b1 && rready === 1'b1) begin
         if (r_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL r_unexpected: rvalid with rdata 0x%0h, required no response", rdata);
         end else begin
            chk("rdata", rdata, r_exp.pop_front());
            chk("rresp", 32'(rresp), 32'(OKAY));
         end
      end
   end

   // Serial-line monitor: every sample of a frame must equal the expected 8N1 bit.
   frame_t      cur_f;
   logic [9:0]  pat;
   logic [3:0]  bidx;
   int unsigned gap = 0;
   int unsigned bad_bits, n_skip;
   initial forever begin
      @(negedge clk);
      if (tx_mon_en && rst_n === 1'b1 && o_tx === 1'b0) begin
         if (tx_exp.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL tx_unexpected: start bit seen, required idle line");
            n_skip = 0;
            while (o_tx === 1'b0 && n_skip < 2000) begin @(negedge clk); n_skip++; end
         end else begin
            mon_busy = 1'b1;
            cur_f = tx_exp.pop_front();
            if (cur_f.b2b) chk("tx_gap", gap, 32'd0);
            pat = {1'b1, cur_f.data, 1'b0};
            bad_bits = 0;
            for (int unsigned k = 0; k < 10 * cur_f.div; k++) begin
               if (k != 0) @(negedge clk);
               bidx = 4'(k / cur_f.div);
               if (o_tx !== pat[bidx]) bad_bits++;
            end
            chk($sformatf("tx_frame_%02h", cur_f.data), bad_bits, 32'd0);
            mon_busy = 1'b0;
         end
         gap = 0;
      end else if (o_tx === 1'b1) begin
         gap++;
      end
   end

   task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] resp);
      int unsigned n = 0;
      b_exp.push_back(resp);
      @(negedge clk);
      awaddr = {28'd0, addr}; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      while (!(awready === 1'b1 && wready === 1'b1) && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         n_vec++; n_err++;
         $display("FAIL aw_timeout: awready/wready %b%b after %0d cycles, required 11", awready, wready, n);
      end
      @(posedge clk); #1;
      awvalid = 1'b0; wvalid = 1'b0;
   endtask

   task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
      int unsigned n = 0;
      r_exp.push_back(exp);
      @(negedge clk);
      araddr = {28'd0, addr}; arvalid = 1'b1;
      while (arready !== 1'b1 && n < 200) begin @(negedge clk); n++; end
      if (n >= 200) begin
         n_vec++; n_err++;
         $display("FAIL ar_timeout: arready %b after %0d cycles, required 1", arready, n);
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
   endtask

   task automatic wait_fall(output int unsigned n);
      n = 0;
      do begin @(negedge clk); n++; end while (o_tx !== 1'b0 && n < 20);
   endtask

   task automatic drain(input int unsigned limit);
      int unsigned n = 0;
      while ((tx_exp.size() != 0 || mon_busy) && n < limit) begin @(negedge clk); n++; end
      chk("drain_pending_frames", 32'(tx_exp.size()) + 32'(mon_busy), 32'd0);
   endtask

   int unsigned n, bad, c0;

   initial begin
      rst_n = 1'b0; awaddr = '0; wdata = '0; wstrb = '0; araddr = '0;
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(o_tx), 32'd1);
      chk("rst_irq", 32'(o_irq), 32'd0);
      chk("rst_axi_ctl", 32'({awready, wready, bvalid, arready, rvalid, bresp, rresp}), 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      rst_n = 1'b1;

      axi_read(4'h4, 32'h0000_0002);
      axi_read(4'h8, 32'h0000_0364);
      axi_read(4'hC, 32'h0000_0000);
      axi_read(4'h0, 32'h0000_0000);

      // Basic frame: o_tx falls two edges after the handshake, seen on the third negedge.
      axi_write(4'h8, 32'd4, 4'hF, OKAY);
      axi_read(4'h8, 32'd4);
      tx_exp.push_back('{8'hA5, 4, 1'b0});
      axi_write(4'h0, 32'h0000_00A5, 4'h1, OKAY);
      wait_fall(n);
      chk("tx_start_latency", n, 32'd3);
      axi_read(4'h4, 32'h0000_0006);
      drain(200);

      axi_write(4'h8, 32'd77, 4'h0, OKAY);
      axi_read(4'h8, 32'd4);

      // Overflow: one byte in the shifter plus eight queued; the tenth is refused.
      axi_write(4'h8, 32'd100, 4'hF, OKAY);
      for (int i = 0; i < 10; i++) begin
         if (i < 9) tx_exp.push_back('{8'(8'h30 + i), 100, (i != 0)});
         axi_write(4'h0, 32'(8'h30 + i), 4'h1, (i < 9) ? OKAY : SLVERR);
      end
      axi_read(4'h4, 32'h0000_0805);
      drain(12000);

      // Backpressure on B.
      @(posedge clk); #1 bready = 1'b0;
      axi_write(4'h8, 32'd6, 4'hF, OKAY);
      fork
         axi_write(4'h8, 32'd4, 4'hF, OKAY);
      join_none
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (!(bvalid === 1'b1 && awready === 1'b0 && wready === 1'b0)) bad++;
      end
      chk("bp_hold", bad, 32'd0);
      @(posedge clk); #1 bready = 1'b1;
      wait fork;
      axi_read(4'h8, 32'd4);

      // DIV change mid-frame applies only to the following frame.
      tx_exp.push_back('{8'h3C, 4, 1'b0});
      axi_write(4'h0, 32'h0000_003C, 4'h1, OKAY);
      repeat (10) @(negedge clk);
      axi_write(4'h8, 32'd8, 4'hF, OKAY);
      tx_exp.push_back('{8'h81, 8, 1'b1});
      axi_write(4'h0, 32'h0000_0081, 4'h1, OKAY);
      drain(300);

      axi_write(4'h8, 32'd0, 4'hF, OKAY);
      axi_read(4'h8, 32'd0);
      tx_exp.push_back('{8'h5A, 1, 1'b0});
      axi_write(4'h0, 32'h0000_005A, 4'h1, OKAY);
      drain(100);

      // Interrupt: low while the frame runs, high from the 40th negedge after the start bit.
      axi_write(4'h8, 32'd4, 4'hF, OKAY);
      axi_write(4'hC, 32'd1, 4'h1, OKAY);
      axi_read(4'hC, 32'(IRQ_ON));
      tx_exp.push_back('{8'hC3, 4, 1'b0});
      axi_write(4'h0, 32'h0000_00C3, 4'h1, OKAY);
      wait_fall(n);
      chk("irq_tx_latency", n, 32'd3);
      bad = 0;
      for (int unsigned k = 1; k <= 45; k++) begin
         @(negedge clk);
         if (o_irq !== (IRQ_ON && k >= 40)) bad++;
      end
      chk("irq_profile", bad, 32'd0);
      drain(100);

      // Reset during DATA: line returns high without a clock edge; queued byte is lost.
      tx_mon_en = 1'b0;
      axi_write(4'h0, 32'h0000_0011, 4'h1, OKAY);
      wait_fall(n);
      c0 = cyc;
      axi_write(4'h0, 32'h0000_0022, 4'h1, OKAY);
      while (cyc < c0 + 9) @(negedge clk);
      chk("pre_reset_tx_bit1", 32'(o_tx), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_tx", 32'(o_tx), 32'd1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      axi_read(4'h4, 32'h0000_0002);
      axi_read(4'h8, 32'h0000_0364);
      axi_read(4'hC, 32'h0000_0000);
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (o_tx !== 1'b1) bad++;
      end
      chk("post_reset_idle", bad, 32'd0);

      n = 0;
      while ((b_exp.size() != 0 || r_exp.size() != 0) && n < 50) begin @(negedge clk); n++; end
      chk("scoreboard_empty", 32'(b_exp.size()) + 32'(r_exp.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
